// File: rtl/taillight_ctrl.sv
// ---------------------------------------------------------------------------
// taillight_ctrl
//   Sequential tail-light controller. A prescaler produces a one-cycle `step`
//   pulse every TICK_DIV clocks, and the light state machine moves only on
//   those pulses. Left and right turn requests run a three-lamp "sweep" from
//   the inner lamp outward. A hazard request, or left and right together,
//   flashes all six lamps. The brake lights every lamp on a side that is not
//   sweeping. Hazard flashing ignores the brake.
//
// Parameters
//   TICK_DIV  clk cycles per sequencing step (1..255)
//
// Ports
//   clk                 system clock, rising edge
//   reset               synchronous, active-high reset
//   left, right         turn requests (level)
//   hazard              hazard flasher request (level)
//   brake               brake pedal (level)
//   la, lb, lc          left lamps, inner to outer
//   ra, rb, rc          right lamps, inner to outer
//   busy                high whenever the state machine is not IDLE
//   step                one-cycle prescaler pulse
// ---------------------------------------------------------------------------
module taillight_ctrl #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  input  logic hazard,
  input  logic brake,
  output logic la,
  output logic lb,
  output logic lc,
  output logic ra,
  output logic rb,
  output logic rc,
  output logic busy,
  output logic step
);

  typedef enum logic [3:0] {
    IDLE, L1, L2, L3, R1, R2, R3, H_ON, H_OFF
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(TICK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tick;
  logic       hz_req;

  // ---------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------
  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (tick) begin
      cnt_d = 8'd0;
    end
  end

  // ---------------------------------------------------------------------
  // Light sequencer
  // ---------------------------------------------------------------------
  assign hz_req = hazard | (left & right);

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (hz_req)     state_d = H_ON;
          else if (left)  state_d = L1;
          else if (right) state_d = R1;
          else            state_d = IDLE;
        end
        // Once started, a sweep runs to its end; only a hazard cuts it short.
        L1:      state_d = hz_req ? H_ON : L2;
        L2:      state_d = hz_req ? H_ON : L3;
        L3:      state_d = hz_req ? H_ON : IDLE;
        R1:      state_d = hz_req ? H_ON : R2;
        R2:      state_d = hz_req ? H_ON : R3;
        R3:      state_d = hz_req ? H_ON : IDLE;
        H_ON:    state_d = H_OFF;
        H_OFF:   state_d = hz_req ? H_ON : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Lamp decode
  // ---------------------------------------------------------------------
  logic [1:0] left_len, right_len;   // number of lamps lit by a sweep
  logic       left_seq, right_seq;   // that side is currently sweeping
  logic       hz_on, hz_mode;
  logic [2:0] left_pat, right_pat;   // bit 0 = inner lamp
  logic [2:0] left_lamps, right_lamps;

  always_comb begin
    left_len  = 2'd0;
    right_len = 2'd0;
    left_seq  = 1'b0;
    right_seq = 1'b0;
    hz_on     = 1'b0;
    hz_mode   = 1'b0;
    case (state_q)
      L1:    begin left_len  = 2'd1; left_seq  = 1'b1; end
      L2:    begin left_len  = 2'd2; left_seq  = 1'b1; end
      L3:    begin left_len  = 2'd3; left_seq  = 1'b1; end
      R1:    begin right_len = 2'd1; right_seq = 1'b1; end
      R2:    begin right_len = 2'd2; right_seq = 1'b1; end
      R3:    begin right_len = 2'd3; right_seq = 1'b1; end
      H_ON:  begin hz_on = 1'b1; hz_mode = 1'b1; end
      H_OFF: begin hz_mode = 1'b1; end
      default: ;
    endcase
  end

  // Thermometer pattern: lamp gi is lit once the sweep has passed it.
  for (genvar gi = 0; gi < 3; gi++) begin : g_pat
    assign left_pat[gi]  = (left_len  > 2'(gi));
    assign right_pat[gi] = (right_len > 2'(gi));
  end

  always_comb begin
    left_lamps  = 3'b000;
    right_lamps = 3'b000;
    busy        = 1'b0;
    step        = 1'b0;
    // Reset blanks every output, whatever the state or brake.
    if (!reset) begin
      if (hz_on) begin
        left_lamps  = 3'b111;
        right_lamps = 3'b111;
      end else if (!hz_mode) begin
        left_lamps  = left_pat  | ((brake && !left_seq)  ? 3'b111 : 3'b000);
        right_lamps = right_pat | ((brake && !right_seq) ? 3'b111 : 3'b000);
      end
      busy = (state_q != IDLE);
      step = tick;
    end
  end

  assign la = left_lamps[0];
  assign lb = left_lamps[1];
  assign lc = left_lamps[2];
  assign ra = right_lamps[0];
  assign rb = right_lamps[1];
  assign rc = right_lamps[2];

endmodule

// File: tb/tb_taillight_ctrl.sv
// ---------------------------------------------------------------------------
// tb_taillight_ctrl
//   Self-checking bench for taillight_ctrl with TICK_DIV=2. A behavioural
//   model (mode + sweep position + cycle counter) predicts every output each
//   cycle. Directed scenarios carry hand-written literal expectations, then a
//   randomized run exercises the remaining combinations.
// ---------------------------------------------------------------------------
module tb_taillight_ctrl;

  localparam int TD = 2;

  // Model modes
  localparam int M_IDLE  = 0;
  localparam int M_LEFT  = 1;
  localparam int M_RIGHT = 2;
  localparam int M_HON   = 3;
  localparam int M_HOFF  = 4;

  logic clk = 1'b0;
  logic reset, left, right, hazard, brake;
  logic la, lb, lc, ra, rb, rc, busy, step;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_cnt  = 0;
  int m_mode = M_IDLE;
  int m_pos  = 0;

  taillight_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .hazard(hazard), .brake(brake),
    .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
    .busy(busy), .step(step)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Behavioural model: advances on each rising edge.
  // ---------------------------------------------------------------------
  always @(posedge clk) begin
    int  nmode, npos;
    bit  hz, st;
    nmode = m_mode;
    npos  = m_pos;
    if (reset) begin
      m_cnt  <= 0;
      m_mode <= M_IDLE;
      m_pos  <= 0;
    end else begin
      st = (m_cnt == TD - 1);
      hz = hazard | (left & right);
      if (st) begin
        if (m_mode == M_IDLE) begin
          if (hz)         begin nmode = M_HON; npos = 0; end
          else if (left)  begin nmode = M_LEFT;  npos = 1; end
          else if (right) begin nmode = M_RIGHT; npos = 1; end
        end else if (m_mode == M_LEFT || m_mode == M_RIGHT) begin
          if (hz) begin nmode = M_HON; npos = 0; end
          else if (m_pos == 3) begin nmode = M_IDLE; npos = 0; end
          else npos = m_pos + 1;
        end else if (m_mode == M_HON) begin
          nmode = M_HOFF;
        end else begin
          nmode = hz ? M_HON : M_IDLE;
        end
      end
      m_cnt  <= (m_cnt + 1) % TD;
      m_mode <= nmode;
      m_pos  <= npos;
    end
  end

  function automatic logic [2:0] sweep(input int p);
    int v;
    v = (7 << (3 - p)) & 7;
    return 3'(v);
  endfunction

  // ---------------------------------------------------------------------
  // Per-cycle comparison against the model.
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    logic [2:0] el, er;
    logic       eb, es;
    #2;
    if (chk_en) begin
      el = 3'b000; er = 3'b000; eb = 1'b0; es = 1'b0;
      if (!reset) begin
        case (m_mode)
          M_HON:   begin el = 3'b111; er = 3'b111; end
          M_HOFF:  ;
          M_LEFT:  begin el = sweep(m_pos); er = brake ? 3'b111 : 3'b000; end
          M_RIGHT: begin er = sweep(m_pos); el = brake ? 3'b111 : 3'b000; end
          default: begin el = brake ? 3'b111 : 3'b000; er = el; end
        endcase
        eb = (m_mode != M_IDLE);
        es = (m_cnt == TD - 1);
      end
      checks++;
      if ({la, lb, lc, ra, rb, rc, busy, step} !== {el, er, eb, es}) begin
        errors++;
        $display("FAIL model t=%0t lamps/busy/step got %b%b%b%b%b%b/%b/%b expected %b%b/%b/%b",
                 $time, la, lb, lc, ra, rb, rc, busy, step, el, er, eb, es);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic nstep();
    tick();
    tick();
  endtask

  task automatic chk(input string nm, input logic [5:0] el, input logic eb, input logic es);
    #3;
    checks++;
    if ({la, lb, lc, ra, rb, rc} !== el || busy !== eb || step !== es) begin
      errors++;
      $display("FAIL %s: got lamps=%b busy=%b step=%b, expected lamps=%b busy=%b step=%b",
               nm, {la, lb, lc, ra, rb, rc}, busy, step, el, eb, es);
    end else begin
      $display("check %s lamps=%b busy=%b step=%b ok", nm, el, eb, es);
    end
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    chk("reset_with_brake", 6'b000000, 1'b0, 1'b0);

    // Left held: sweep, return to IDLE, restart.
    do_reset();
    left = 1'b1;
    chk("left_release", 6'b000000, 1'b0, 1'b0);
    tick();  chk("left_first_step", 6'b000000, 1'b0, 1'b1);
    tick();  chk("left_L1", 6'b100000, 1'b1, 1'b0);
    nstep(); chk("left_L2", 6'b110000, 1'b1, 1'b0);
    nstep(); chk("left_L3", 6'b111000, 1'b1, 1'b0);
    nstep(); chk("left_done", 6'b000000, 1'b0, 1'b0);
    nstep(); chk("left_again", 6'b100000, 1'b1, 1'b0);

    // Right pulse missing a step is ignored; covering a step starts a sweep.
    do_reset();
    right = 1'b1;
    tick();  right = 1'b0;
    tick();  chk("right_short_pulse", 6'b000000, 1'b0, 1'b0);
    right = 1'b1;
    nstep(); right = 1'b0;
    chk("right_R1", 6'b000100, 1'b1, 1'b0);
    nstep(); chk("right_R2", 6'b000110, 1'b1, 1'b0);
    nstep(); chk("right_R3", 6'b000111, 1'b1, 1'b0);
    nstep(); chk("right_done", 6'b000000, 1'b0, 1'b0);

    // Hazard preempts a left sweep, flashes, then winds down.
    do_reset();
    left = 1'b1;
    nstep(); left = 1'b0;
    nstep(); chk("haz_pre_L2", 6'b110000, 1'b1, 1'b0);
    hazard = 1'b1;
    nstep(); chk("haz_on1", 6'b111111, 1'b1, 1'b0);
    nstep(); chk("haz_off1", 6'b000000, 1'b1, 1'b0);
    nstep(); chk("haz_on2", 6'b111111, 1'b1, 1'b0);
    hazard = 1'b0;
    nstep(); brake = 1'b1;
    chk("haz_off_brake", 6'b000000, 1'b1, 1'b0);
    tick();  brake = 1'b0;
    tick();  chk("haz_idle", 6'b000000, 1'b0, 1'b0);

    // Left and right together means hazard.
    do_reset();
    left = 1'b1; right = 1'b1;
    nstep(); chk("both_hon", 6'b111111, 1'b1, 1'b0);
    left = 1'b0; right = 1'b0;
    nstep(); chk("both_hoff", 6'b000000, 1'b1, 1'b0);
    nstep(); chk("both_idle", 6'b000000, 1'b0, 1'b0);

    // Brake in IDLE and during a left sweep.
    do_reset();
    brake = 1'b1;
    chk("brake_idle", 6'b111111, 1'b0, 1'b0);
    brake = 1'b0; left = 1'b1;
    nstep(); left = 1'b0; brake = 1'b1;
    chk("brake_L1", 6'b100111, 1'b1, 1'b0);
    brake = 1'b0;

    // Reset during R2 with brake applied; step phase after release.
    do_reset();
    right = 1'b1;
    nstep(); right = 1'b0;
    nstep(); chk("rst_pre_R2", 6'b000110, 1'b1, 1'b0);
    reset = 1'b1; brake = 1'b1;
    chk("rst_in_R2", 6'b000000, 1'b0, 1'b0);
    tick();  reset = 1'b0; brake = 1'b0;
    chk("rst_rel_c1", 6'b000000, 1'b0, 1'b0);
    tick();  chk("rst_rel_c2", 6'b000000, 1'b0, 1'b1);
    tick();  chk("rst_rel_c3", 6'b000000, 1'b0, 1'b0);
    tick();  chk("rst_rel_c4", 6'b000000, 1'b0, 1'b1);
    tick();  chk("rst_rel_c5", 6'b000000, 1'b0, 1'b0);
    tick();  chk("rst_rel_c6", 6'b000000, 1'b0, 1'b1);

    // Randomized run: inputs toggle occasionally so levels persist.
    for (int i = 0; i < 4000; i++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0)  left   = ~left;
      if ($urandom_range(0, 5) == 0)  right  = ~right;
      if ($urandom_range(0, 15) == 0) hazard = ~hazard;
      if ($urandom_range(0, 3) == 0)  brake  = ~brake;
    end

    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
